wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Writer-side front end of the integer register file. Merges in-order pipeline writeback
//  and out-of-order results from a multi-cycle unit (mul/div, long loads) onto the regfile's
//  single write port (wr_en/wr_addr/wr_data). Keeps a 32-entry pending-write scoreboard
//  that ID uses to stall on operands not yet written.
// PARAMETERS
//  FIFO_DEPTH  4   multi-cycle result buffer entries; power of 2, >=2
//  XLEN        32  register data width
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous reset, active-high
//  pipe_wr_en    in   1     pipeline WB write request; always granted, never stalled
//  pipe_wr_addr  in   5     pipeline WB destination register
//  pipe_wr_data  in   XLEN  pipeline WB data
//  mc_valid      in   1     multi-cycle result valid
//  mc_ready      out  1     arbiter can accept a multi-cycle result
//  mc_addr       in   5     multi-cycle destination register
//  mc_data       in   XLEN  multi-cycle result data
//  issue_en      in   1     ID issued a multi-cycle op; mark issue_addr pending
//  issue_addr    in   5     destination of the issued multi-cycle op
//  rf_wr_en      out  1     regfile write enable
//  rf_wr_addr    out  5     regfile write address
//  rf_wr_data    out  XLEN  regfile write data
//  busy          out  32    scoreboard; busy[r]=1 means a multi-cycle write to r is pending
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  buffered entries
// BEHAVIOUR
//  - Reset: FIFO empty, fifo_count=0, busy=0. While rst=1, rf_wr_en=0 and mc_ready=0.
//    Reset during operation discards buffered results and clears all busy bits next cycle.
//  - Accept: mc_valid & mc_ready pushes {mc_addr,mc_data} at the clock edge.
//    mc_ready = ~full & ~rst; it ignores a same-cycle pop. mc_* must stay stable while
//    mc_valid=1 & mc_ready=0.
//  - Grant (combinational): pipe_wr_en=1 drives rf_wr_* from pipe_*. Otherwise a non-empty
//    FIFO drives rf_wr_* from its head and pops it at the edge. Otherwise rf_wr_en=0.
//  - Latency: a result accepted at edge N is written at the earliest in the cycle after N.
//    Each cycle with pipe_wr_en=1 delays the FIFO head by one cycle.
//  - No FIFO bypass: mc_data is never written in its own acceptance cycle.
//  - x0: a request with addr 0 is granted and consumes its slot, but rf_wr_en=0. issue_addr=0
//    never sets busy[0]; busy[0] is always 0.
//  - Scoreboard: issue_en sets busy[issue_addr]. A FIFO pop clears busy[rf_wr_addr].
//    A set and a clear of the same register in one cycle: set wins.
//  - Pipeline writes never change busy. ID must stall any issue whose rd is busy;
//    issue_en to a busy register is illegal and covered by an assertion.
//  - Full FIFO with a pipeline write every cycle: mc_ready stays 0 and no push occurs.
//    The pipeline is never blocked.
//  - Pointer arithmetic is modulo FIFO_DEPTH. fifo_count goes 0..FIFO_DEPTH.
//    Push and pop together leave fifo_count unchanged.
// STRUCTURE
//  - Shared package riscv_pkg: wb_req_t struct {logic[4:0] addr; logic[XLEN-1:0] data;}
//    and REG_ADDR_ZERO / REG_DATA_ZERO, shared with defines.sv users.
//  - Sub-module sync_fifo: parameterised width/depth; push/pop/full/empty/count ports; no
//    bypass. The arbiter holds the grant mux and scoreboard only.
// TESTING
//  - Reset mid-burst: 3 results buffered, busy=0x0000_000E, pulse rst -> next cycle
//    fifo_count=0, busy=0, rf_wr_en=0, mc_ready=1 after rst falls.
//  - Idle pipe: issue x5; 2 cycles later mc result x5=0xDEADBEEF accepted -> next cycle
//    rf_wr_en=1, addr=5, data=0xDEADBEEF; busy[5] clears the cycle after.
//  - Conflict: pipe_wr_en=1 every cycle for 6 cycles with 5 mc pushes (x1..x5) ->
//    4 pushes accepted, mc_ready=0 on the 5th; all pipe writes granted. After pipe stops,
//    x1..x4 written in order on consecutive cycles.
//  - x0 handling: pipe write x0=0x1234 -> rf_wr_en=0. mc result x0 pops with rf_wr_en=0.
//    issue_en x0 -> busy=0.
//  - Set/clear race: busy[7]=1; x7 pops the same cycle issue_en x7 -> busy[7] stays 1.
//  - Full with simultaneous pop: FIFO full, pipe idle -> pop occurs, mc_ready=0 that cycle,
//    mc_ready=1 next cycle, fifo_count FIFO_DEPTH-1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared integer-core types and constants. Holds the
//               register-file write request type and the register/data zero
//               constants used by the writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int RV_XLEN    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ADDR_ZERO = '0;
    localparam logic [RV_XLEN-1:0]    REG_DATA_ZERO = '0;

    // One register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [RV_XLEN-1:0]    data;
    } wb_req_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered occupancy count. Read data
//               is the current head (show-ahead). There is no write-to-read
//               bypass: an entry pushed at an edge is visible only afterwards.
//               A push while full or a pop while empty is ignored.
// Ports       : clk, rst        clock, synchronous active-high reset
//               push, wr_data   write strobe and data
//               pop, rd_data    read strobe and head data
//               full, empty     occupancy flags
//               count           entries held, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4      // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH_CNT = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W:0]   r_count_q,  w_count_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count_q == c_DEPTH_CNT);
    assign empty     = (r_count_q == '0);
    assign count     = r_count_q;
    assign rd_data   = r_mem[r_rd_ptr_q];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits wide, so natural overflow
    // gives the modulo-DEPTH wrap.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push_ok) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_pop_ok)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset; the count and pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr_q] <= wr_data;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Writer-side front end of the integer register file. Merges
//               in-order pipeline writeback with buffered multi-cycle results
//               onto the single regfile write port, and keeps a pending-write
//               scoreboard for operand-hazard stalls in ID.
// Ports       : clk, rst                         clock, sync active-high reset
//               pipe_wr_en/addr/data             pipeline WB write (never stalled)
//               mc_valid/ready/addr/data         multi-cycle result handshake
//               issue_en, issue_addr             mark a destination pending
//               rf_wr_en/addr/data               regfile write port
//               busy                             pending-write scoreboard
//               fifo_count                       buffered multi-cycle results
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_wr_en,
    input  logic [4:0]                    pipe_wr_addr,
    input  logic [XLEN-1:0]               pipe_wr_data,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [4:0]                    mc_addr,
    input  logic [XLEN-1:0]               mc_data,
    input  logic                          issue_en,
    input  logic [4:0]                    issue_addr,
    output logic                          rf_wr_en,
    output logic [4:0]                    rf_wr_addr,
    output logic [XLEN-1:0]               rf_wr_data,
    output logic [31:0]                   busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ENTRY_W = REG_ADDR_W + XLEN;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [c_ENTRY_W-1:0]    w_head;
    logic [REG_ADDR_W-1:0]   w_head_addr;
    logic [XLEN-1:0]         w_head_data;
    logic [NUM_REGS-1:0]     r_busy_q, w_busy_d;

    // Readiness deliberately ignores a same-cycle pop to keep the handshake
    // off the grant path.
    assign mc_ready = ~w_full & ~rst;
    assign w_push   = mc_valid & mc_ready;

    assign w_head_addr = w_head[c_ENTRY_W-1 -: REG_ADDR_W];
    assign w_head_data = w_head[XLEN-1:0];

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data ({mc_addr, mc_data}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    // Grant: pipeline always wins; otherwise drain the buffer head. A write
    // to x0 still consumes its slot but never asserts the enable.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = REG_ADDR_ZERO;
        rf_wr_data = '0;
        w_pop      = 1'b0;
        if (!rst) begin
            if (pipe_wr_en) begin
                rf_wr_en   = (pipe_wr_addr != REG_ADDR_ZERO);
                rf_wr_addr = pipe_wr_addr;
                rf_wr_data = pipe_wr_data;
            end else if (!w_empty) begin
                w_pop      = 1'b1;
                rf_wr_en   = (w_head_addr != REG_ADDR_ZERO);
                rf_wr_addr = w_head_addr;
                rf_wr_data = w_head_data;
            end
        end
    end

    // Scoreboard: the set is applied after the clear so a same-cycle
    // issue to the register being retired keeps it pending.
    always_comb begin
        w_busy_d = r_busy_q;
        if (w_pop)
            w_busy_d[w_head_addr] = 1'b0;
        if (issue_en && (issue_addr != REG_ADDR_ZERO))
            w_busy_d[issue_addr] = 1'b1;
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy_q <= '0;
        else     r_busy_q <= w_busy_d;
    end

    assign busy = r_busy_q;

    // Issuing to a pending register is an ID stall bug, except when that
    // register's pending write retires in the same cycle.
    a_no_issue_to_busy : assert property (@(posedge clk) disable iff (rst)
        !(issue_en && r_busy_q[issue_addr] && !(w_pop && (w_head_addr == issue_addr))));

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Directed self-checking bench for wb_write_arbiter. Expected
//               regfile writes are queued as stimulus is applied and matched
//               in order against the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int XLEN       = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_wr_en;
    logic [4:0]      pipe_wr_addr;
    logic [XLEN-1:0] pipe_wr_data;
    logic            mc_valid;
    logic            mc_ready;
    logic [4:0]      mc_addr;
    logic [XLEN-1:0] mc_data;
    logic            issue_en;
    logic [4:0]      issue_addr;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic [31:0]     busy;
    logic [2:0]      fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_write_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_addr      (mc_addr),
        .mc_data      (mc_data),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every enabled regfile write must match the oldest expectation.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, rf_wr_addr, rf_wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("rf_write", {27'd0, rf_wr_addr, rf_wr_data}, {27'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0; issue_en = 1'b0; issue_addr = '0;

        // ---- reset state ----
        tick(); tick();
        #1;
        check("rst_rf_wr_en", rf_wr_en, 0);
        check("rst_mc_ready", mc_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", mc_ready, 1);

        // ---- idle pipe: issue x5, result two cycles later ----
        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        issue_en = 1'b0;
        #1 check("busy_x5_set", busy, 32'h20);
        tick(); tick();
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        #1;
        check("accept_ready", mc_ready, 1);
        check("no_bypass", rf_wr_en, 0);
        tick();
        mc_valid = 1'b0;
        #1;
        check("mc_write_en", rf_wr_en, 1);
        check("busy_x5_pop_cycle", busy, 32'h20);
        tick();
        check("busy_x5_cleared", busy, 0);
        check("count_after_x5", fifo_count, 0);

        // ---- conflict: pipe every cycle, five mc results ----
        for (int i = 0; i < 6; i++) begin
            pipe_wr_en = 1'b1; pipe_wr_addr = 5'(10 + i); pipe_wr_data = 32'hA000_0000 + i;
            exp_q.push_back({5'(10 + i), 32'hA000_0000 + 32'(i)});
            if (i < 5) begin
                mc_valid = 1'b1; mc_addr = 5'(i + 1); mc_data = 32'h100 + 32'(i);
            end
            #1;
            if (i < 4) check("conflict_ready", mc_ready, 1);
            else       check("conflict_full", mc_ready, 0);
            tick();
        end
        pipe_wr_en = 1'b0; mc_valid = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back({5'(k + 1), 32'h100 + 32'(k)});
        #1;
        check("conflict_count", fifo_count, 4);
        check("conflict_ready_popcycle", mc_ready, 0);
        tick(); tick(); tick(); tick();
        check("conflict_drained", fifo_count, 0);

        // ---- x0 handling ----
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'h1234;
        #1 check("pipe_x0_en", rf_wr_en, 0);
        tick();
        pipe_wr_en = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h55;
        tick();
        mc_valid = 1'b0;
        #1;
        check("mc_x0_count", fifo_count, 1);
        check("mc_x0_en", rf_wr_en, 0);
        tick();
        check("mc_x0_popped", fifo_count, 0);
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        issue_en = 1'b0;
        #1 check("issue_x0_busy", busy, 0);

        // ---- set/clear race on x7 ----
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        issue_en = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        tick();
        mc_valid = 1'b0;
        issue_en = 1'b1; issue_addr = 5'd7;
        #1 check("race_pop_en", rf_wr_en, 1);
        tick();
        issue_en = 1'b0;
        #1 check("race_set_wins", busy, 32'h80);

        // ---- full FIFO with pop and idle pipe ----
        for (int i = 0; i < 4; i++) begin
            pipe_wr_en = 1'b1; pipe_wr_addr = 5'd20; pipe_wr_data = 32'hB0 + 32'(i);
            exp_q.push_back({5'd20, 32'hB0 + 32'(i)});
            mc_valid = 1'b1; mc_addr = 5'(8 + i); mc_data = 32'hC00 + 32'(i);
            tick();
        end
        pipe_wr_en = 1'b0; mc_valid = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back({5'(8 + k), 32'hC00 + 32'(k)});
        #1;
        check("full_ready", mc_ready, 0);
        check("full_count", fifo_count, 4);
        check("full_pop_en", rf_wr_en, 1);
        tick();
        check("after_pop_ready", mc_ready, 1);
        check("after_pop_count", fifo_count, 3);
        tick(); tick(); tick();
        check("full_drained", fifo_count, 0);

        // ---- reset mid-burst ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            issue_en = 1'b1; issue_addr = 5'(i);
            tick();
        end
        issue_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            pipe_wr_en = 1'b1; pipe_wr_addr = 5'd21; pipe_wr_data = 32'hD0 + 32'(i);
            exp_q.push_back({5'd21, 32'hD0 + 32'(i)});
            mc_valid = 1'b1; mc_addr = 5'(i); mc_data = 32'hE0 + 32'(i);
            tick();
        end
        pipe_wr_en = 1'b0; mc_valid = 1'b0;
        #1;
        check("burst_busy", busy, 32'h0000_000E);
        check("burst_count", fifo_count, 3);
        rst = 1'b1;
        #1;
        check("burst_rst_en", rf_wr_en, 0);
        check("burst_rst_ready", mc_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("burst_count_cleared", fifo_count, 0);
        check("burst_busy_cleared", busy, 0);
        check("burst_rf_en", rf_wr_en, 0);
        check("burst_ready_after", mc_ready, 1);
        tick(); tick(); tick();

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire
